// File: rtl/fetch_unit.sv
// fetch_unit: issues line bursts, splits 64-bit beats into two instructions and
// queues them with their PC for the decoder; redirect flushes and drains.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          BEATS    = 8,
  parameter int          QDEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        bus_reqcyc,
  output logic [63:0] bus_req,
  input  logic        bus_reqack,
  input  logic        bus_respcyc,
  input  logic [63:0] bus_resp,
  output logic        bus_respack,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [63:0] cur_pc,
  input  logic        instr_ready
);
  localparam int LB = $clog2(8 * BEATS);
  localparam int QW = $clog2(QDEPTH);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [QW:0] MAXFILL = (QW + 1)'(QDEPTH - 2 * BEATS);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DRAIN = 2'd3;

  logic [1:0]    r_state;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_req;
  logic [BW-1:0] r_beat;
  logic          r_redir;
  logic [QW:0]   r_wr;
  logic [QW:0]   r_rd;
  logic [95:0]   r_mem [QDEPTH];

  logic [QW:0]   w_count;
  logic          w_room;
  logic          w_beat;
  logic          w_last;
  logic          w_enq;
  logic          w_lo_en;
  logic          w_hi_en;
  logic          w_deq;
  logic [63:0]   w_lo_addr;
  logic [63:0]   w_hi_addr;
  logic [QW-1:0] w_hi_idx;
  logic [95:0]   w_head;

  assign w_count     = r_wr - r_rd;
  assign w_room      = w_count <= MAXFILL;
  assign w_beat      = (r_state == RESP || r_state == DRAIN) && bus_respcyc;
  assign w_last      = r_beat == BW'(BEATS - 1);
  assign w_lo_addr   = r_req | {{(61 - BW){1'b0}}, r_beat, 3'b000};
  assign w_hi_addr   = w_lo_addr | 64'd4;
  // Halves below the entry point of the line are dropped, not queued.
  assign w_enq       = r_state == RESP && bus_respcyc && !redirect_valid;
  assign w_lo_en     = w_enq && w_lo_addr >= r_fetch_pc;
  assign w_hi_en     = w_enq && w_hi_addr >= r_fetch_pc;
  assign w_hi_idx    = r_wr[QW-1:0] + {{(QW - 1){1'b0}}, w_lo_en};
  assign w_deq       = instr_valid && instr_ready && !redirect_valid;
  assign w_head      = r_mem[r_rd[QW-1:0]];

  assign bus_reqcyc  = r_state == REQ;
  assign bus_req     = r_req;
  assign bus_respack = w_beat;
  assign instr_valid = r_wr != r_rd;
  assign instruction = instr_valid ? w_head[31:0] : 32'd0;
  assign cur_pc      = instr_valid ? w_head[95:32] : 64'd0;

  always_ff @(posedge clk) begin
    if (w_lo_en) r_mem[r_wr[QW-1:0]] <= {w_lo_addr, bus_resp[31:0]};
    if (w_hi_en) r_mem[w_hi_idx] <= {w_hi_addr, bus_resp[63:32]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 64'd0;
      r_beat     <= '0;
      r_redir    <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_wr <= r_wr + {{QW{1'b0}}, w_lo_en} + {{QW{1'b0}}, w_hi_en};
      r_rd <= redirect_valid ? r_wr : r_rd + {{QW{1'b0}}, w_deq};
      if (w_beat) r_beat <= r_beat + BW'(1);
      if (redirect_valid) r_fetch_pc <= {redirect_pc[63:2], 2'b00};
      else if (w_enq && w_last) r_fetch_pc <= r_req + 64'(8 * BEATS);
      case (r_state)
        IDLE: if (!redirect_valid && w_room) begin
          r_state <= REQ;
          r_req   <= {r_fetch_pc[63:LB], {LB{1'b0}}};
        end
        REQ: begin
          if (redirect_valid) r_redir <= 1'b1;
          if (bus_reqack) begin
            r_state <= (r_redir || redirect_valid) ? DRAIN : RESP;
            r_beat  <= '0;
            r_redir <= 1'b0;
          end
        end
        RESP: begin
          if (w_beat && w_last) r_state <= IDLE;
          else if (redirect_valid) r_state <= DRAIN;
        end
        default: if (w_beat && w_last) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bus responder and decoder against a sequential-PC model.
module tb_fetch_unit;
  localparam logic [63:0] RPC = 64'h1000;
  localparam int BEATS = 8;

  logic        clk;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic        bus_respack;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [63:0] cur_pc;
  logic        instr_ready;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_consumed = 0;
  logic [63:0] exp_pc = RPC;
  logic [63:0] reqs[$];
  int          cur_beat;
  int          ack_max = 0;
  bit          ack_rand = 0;
  int          gap_max = 0;
  bit          hold_rdy = 1;

  fetch_unit #(.RESET_PC(RPC), .BEATS(BEATS), .QDEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instruction(instruction), .cur_pc(cur_pc),
    .instr_ready(instr_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memfn(logic [63:0] a);
    return 32'((a - RPC) >> 2);
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_reqs(int n);
    int i;
    for (i = 0; i < 3000 && reqs.size() < n; i++) @(posedge clk);
    #2;
    check("wait_reqs", 64'(reqs.size() >= n), 64'd1);
  endtask

  task automatic wait_consumed(int n);
    int i;
    for (i = 0; i < 3000 && n_consumed < n; i++) @(posedge clk);
    check("wait_consumed", 64'(n_consumed >= n), 64'd1);
  endtask

  task automatic wait_beat(int b);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (bus_respcyc && cur_beat == b) break;
    end
    check("wait_beat", 64'(i < 3000), 64'd1);
  endtask

  task automatic pulse_redirect(logic [63:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    @(posedge clk); #1;
    redirect_valid = 0;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'd0);
    check({tag, "_req"}, bus_req, 64'd0);
    check({tag, "_respack"}, 64'(bus_respack), 64'd0);
    check({tag, "_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_instr"}, 64'(instruction), 64'd0);
    check({tag, "_pc"}, cur_pc, 64'd0);
  endtask

  // Bus memory model: any address returns memfn(address) for each 32-bit half.
  initial begin
    logic [63:0] base;
    int d, g;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; cur_beat = -1;
    forever begin
      @(posedge clk); #1;
      if (reset && bus_reqcyc) begin
        base = bus_req;
        reqs.push_back(base);
        check("req_align", {58'd0, base[5:0]}, 64'd0);
        d = ack_rand ? int'($urandom_range(0, ack_max)) : ack_max;
        while (reset && d > 0) begin
          @(posedge clk); #1;
          if (reset) begin
            check("req_hold", bus_req, base);
            check("reqcyc_hold", 64'(bus_reqcyc), 64'd1);
          end
          d--;
        end
        if (reset) begin
          bus_reqack = 1;
          @(posedge clk); #1;
          bus_reqack = 0;
        end
        for (int b = 0; b < BEATS && reset; b++) begin
          g = int'($urandom_range(0, gap_max));
          while (reset && g > 0) begin @(posedge clk); #1; g--; end
          if (reset) begin
            bus_respcyc = 1;
            cur_beat = b;
            bus_resp = {memfn(base + 64'(8 * b + 4)), memfn(base + 64'(8 * b))};
            @(negedge clk);
            if (reset) check("respack", 64'(bus_respack), 64'd1);
            @(posedge clk); #1;
            bus_respcyc = 0;
          end
        end
        cur_beat = -1;
      end
    end
  end

  initial begin
    instr_ready = 0;
    forever begin
      @(posedge clk); #1;
      instr_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference: the decoder sees consecutive PCs from the last restart point.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) exp_pc = RPC;
      else if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
      else if (instr_valid && instr_ready) begin
        check("out_pc", cur_pc, exp_pc);
        check("out_instr", 64'(instruction), 64'(memfn(exp_pc)));
        exp_pc += 64'd4;
        n_consumed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [63:0] old;
    reset = 0; redirect_valid = 0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1;

    wait_reqs(1);
    check("first_req", reqs[0], RPC);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("full_no_req", 64'(reqs.size()), 64'd1);
    check("full_reqcyc", 64'(bus_reqcyc), 64'd0);
    check("full_head_pc", cur_pc, RPC);
    check("full_head_instr", 64'(instruction), 64'd0);
    hold_rdy = 0;
    wait_consumed(16);
    wait_reqs(2);
    check("second_req", reqs[1], 64'h1040);

    hold_rdy = 1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("idle_reqcyc", 64'(bus_reqcyc), 64'd0);
    @(posedge clk); #1;
    n0 = reqs.size();
    pulse_redirect(64'h2014);
    @(negedge clk);
    check("flush_idle", 64'(instr_valid), 64'd0);
    wait_reqs(n0 + 1);
    check("redir_idle_req", reqs[n0], 64'h2000);
    for (int i = 0; i < 200 && !instr_valid; i++) @(negedge clk);
    check("redir_head_pc", cur_pc, 64'h2014);
    check("redir_head_instr", 64'(instruction), 64'(memfn(64'h2014)));
    hold_rdy = 0;

    gap_max = 1;
    wait_beat(3);
    n0 = reqs.size();
    redirect_valid = 1;
    redirect_pc = 64'h3000;
    @(posedge clk); #1;
    redirect_valid = 0;
    @(negedge clk);
    check("flush_resp", 64'(instr_valid), 64'd0);
    wait_reqs(n0 + 1);
    check("redir_resp_req", reqs[n0], 64'h3000);

    ack_max = 5;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (bus_reqcyc && !bus_reqack) break;
    end
    n0 = reqs.size();
    old = reqs[n0 - 1];
    redirect_valid = 1;
    redirect_pc = 64'h5008;
    @(posedge clk); #1;
    redirect_valid = 0;
    @(negedge clk);
    check("req_hold_redir", bus_req, old);
    check("reqcyc_hold_redir", 64'(bus_reqcyc), 64'd1);
    wait_reqs(n0 + 1);
    check("redir_req_req", reqs[n0], 64'h5000);
    ack_max = 0;
    wait_consumed(n_consumed + 8);

    wait_beat(2);
    #1;
    reset = 0;
    #1;
    check_zero_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1;
    n0 = reqs.size();
    reset = 1;
    wait_reqs(n0 + 1);
    check("restart_req", reqs[n0], RPC);

    gap_max = 2; ack_rand = 1; ack_max = 3;
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(10, 60)) @(posedge clk);
      #1;
      hold_rdy = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) pulse_redirect(RPC + 64'($urandom_range(0, 4095)));
    end
    hold_rdy = 0;
    n0 = n_consumed;
    repeat (150) @(posedge clk);
    check("progress", 64'(n_consumed > n0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
